// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns ALU address + rs2 into a req/gnt/rvalid
// data-memory transaction and returns extended load data to writeback.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_en,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  lsu_done,
    output logic                  lsu_fault,
    output logic                  stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_f3_ok = 1'b1;
            default:                                load_f3_ok = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = 4'b0011 << off;
            2'b10:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   store_lanes = {4{rs2[7:0]}};
            2'b01:   store_lanes = {2{rs2[15:0]}};
            default: store_lanes = rs2;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b010:  extend_load = rdata;
            3'b100:  extend_load = {24'd0, b};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = 32'd0;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic                    is_load_q, is_load_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
    logic                    lsu_done_q, lsu_done_d;
    logic                    lsu_fault_q, lsu_fault_d;

    logic                    start_s;
    logic [1:0]              off_s;
    logic                    fault_s;

    assign start_s = lsu_en & (mem_read | mem_write);
    assign off_s   = alu_result[1:0];
    assign fault_s = (mem_read ? ~load_f3_ok(funct3) : funct3[2] | (funct3[1:0] == 2'b11))
                   | misaligned(funct3, off_s);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        load_data_d = load_data_q;
        lsu_done_d  = 1'b0;
        lsu_fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    is_load_d = mem_read;
                    funct3_d  = funct3;
                    off_d     = off_s;
                    if (fault_s) begin
                        // Faulting access completes without touching memory
                        state_d     = ST_DONE;
                        lsu_done_d  = 1'b1;
                        lsu_fault_d = 1'b1;
                        if (mem_read) begin
                            load_data_d = '0;
                        end else begin
                            load_data_d = load_data_q;
                        end
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_addr_d  = {alu_result[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = mem_read ? 4'b1111 : store_be(funct3, off_s);
                        mem_wdata_d = mem_read ? store_data : store_lanes(funct3, store_data);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d    = ST_DONE;
                    lsu_done_d = 1'b1;
                    if (is_load_q) begin
                        load_data_d = extend_load(funct3_q, off_q, mem_rdata);
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'd0;
            load_data_q <= '0;
            lsu_done_q  <= 1'b0;
            lsu_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            load_data_q <= load_data_d;
            lsu_done_q  <= lsu_done_d;
            lsu_fault_q <= lsu_fault_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign load_data = load_data_q;
    assign lsu_done  = lsu_done_q;
    assign lsu_fault = lsu_fault_q;
    // Released in DONE so the pipeline can advance
    assign stall     = ((state_q == ST_IDLE) & start_s) | (state_q == ST_REQ) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a scripted memory responder.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_en, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        lsu_done, lsu_fault, stall;

    int passed = 0;
    int total  = 0;

    // Observations from the last run_op
    int          r_done_cyc, r_stall_cyc, r_req_cyc, r_done_cnt;
    logic        r_stable, r_fault, r_we;
    logic [31:0] r_addr, r_wdata, r_ldata;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .lsu_en(lsu_en), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .load_data(load_data), .lsu_done(lsu_done), .lsu_fault(lsu_fault), .stall(stall)
    );

    // Presents one instruction, plays memory with the given grant/response delays and records what it saw
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly, input logic early_rv);
        int   wait_cnt;
        logic granted;
        r_done_cyc = -1; r_stall_cyc = 0; r_req_cyc = 0; r_done_cnt = 0;
        r_stable = 1'b1; r_fault = 1'b0; r_ldata = 32'h0;
        r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0; r_we = 1'b0;
        wait_cnt = 0; granted = 1'b0;
        @(negedge clk);
        lsu_en = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; store_data = sd;
        #1;
        if (stall) r_stall_cyc++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
            if (r_done_cyc < 0 && stall) r_stall_cyc++;
            if (mem_req) begin
                r_req_cyc++;
                if (r_req_cyc == 1) begin
                    r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata; r_we = mem_we;
                end else if (mem_addr !== r_addr || mem_be !== r_be ||
                             mem_wdata !== r_wdata || mem_we !== r_we) begin
                    r_stable = 1'b0;
                end
            end
            if (lsu_done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = c; r_fault = lsu_fault; r_ldata = load_data;
                end
            end
            if (r_done_cyc >= 0 && c == r_done_cyc + 1) lsu_en = 1'b0;
            if (mem_req && !granted && r_req_cyc > gnt_dly) begin
                mem_gnt = 1'b1; granted = 1'b1;
                if (early_rv) begin
                    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
                end
            end else if (granted && r_done_cyc < 0 && !mem_req) begin
                wait_cnt++;
                if (wait_cnt > rv_dly) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end
            end
            if (r_done_cyc >= 0 && c >= r_done_cyc + 3) break;
        end
        lsu_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lsu_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        alu_result = 32'h0; store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if ({mem_req, mem_we, mem_be} !== 6'd0) $display("FAIL rst_ctrl: got %b expected 000000", {mem_req, mem_we, mem_be}); else passed++;
        total++; if ({mem_addr, mem_wdata, load_data} !== 96'd0) $display("FAIL rst_data: got %h expected 0", {mem_addr, mem_wdata, load_data}); else passed++;
        total++; if ({lsu_done, lsu_fault, stall} !== 3'd0) $display("FAIL rst_status: got %b expected 000", {lsu_done, lsu_fault, stall}); else passed++;
    endtask

    task automatic test_sw();
        run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
        total++; if (r_addr !== 32'h100) $display("FAIL sw_addr: got %h expected %h", r_addr, 32'h100); else passed++;
        total++; if (r_be !== 4'b1111) $display("FAIL sw_be: got %b expected 1111", r_be); else passed++;
        total++; if (r_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h expected deadbeef", r_wdata); else passed++;
        total++; if (r_we !== 1'b1) $display("FAIL sw_we: got %b expected 1", r_we); else passed++;
        total++; if (r_done_cyc != 3) $display("FAIL sw_latency: got %0d expected 3", r_done_cyc); else passed++;
        total++; if (r_stall_cyc != 3) $display("FAIL sw_stall: got %0d expected 3", r_stall_cyc); else passed++;
        total++; if (r_done_cnt != 1 || r_fault !== 1'b0) $display("FAIL sw_done: got cnt=%0d fault=%b expected 1/0", r_done_cnt, r_fault); else passed++;
    endtask

    task automatic test_sb_lb();
        run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0);
        total++; if (r_be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", r_be); else passed++;
        total++; if (r_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", r_wdata); else passed++;
        total++; if (r_addr !== 32'h100) $display("FAIL sb_addr: got %h expected 100", r_addr); else passed++;
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 0, 0, 1'b0);
        total++; if (r_ldata !== 32'hFFFFFFA5) $display("FAIL lb_data: got %h expected ffffffa5", r_ldata); else passed++;
        total++; if (r_be !== 4'b1111 || r_we !== 1'b0) $display("FAIL lb_be_we: got %b/%b expected 1111/0", r_be, r_we); else passed++;
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 0, 0, 1'b0);
        total++; if (r_ldata !== 32'h000000A5) $display("FAIL lbu_data: got %h expected 000000a5", r_ldata); else passed++;
        run_op(1'b0, 1'b1, 3'b001, 32'h106, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
        total++; if (r_be !== 4'b1100 || r_wdata !== 32'hABCDABCD) $display("FAIL sh_lanes: got %b/%h expected 1100/abcdabcd", r_be, r_wdata); else passed++;
        total++; if (load_data !== 32'h000000A5) $display("FAIL sh_keeps_load: got %h expected 000000a5", load_data); else passed++;
    endtask

    task automatic test_lh();
        run_op(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 0, 0, 1'b0);
        total++; if (r_ldata !== 32'hFFFF8001) $display("FAIL lh_data: got %h expected ffff8001", r_ldata); else passed++;
        total++; if (r_addr !== 32'h200) $display("FAIL lh_addr: got %h expected 200", r_addr); else passed++;
        run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80017FFF, 0, 0, 1'b0);
        total++; if (r_ldata !== 32'h00008001) $display("FAIL lhu_data: got %h expected 00008001", r_ldata); else passed++;
    endtask

    task automatic test_fault();
        run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0, 0, 1'b0);
        total++; if (r_done_cyc != 1 || r_fault !== 1'b1) $display("FAIL lw_mis_done: got cyc=%0d fault=%b expected 1/1", r_done_cyc, r_fault); else passed++;
        total++; if (r_req_cyc != 0) $display("FAIL lw_mis_noreq: got %0d expected 0", r_req_cyc); else passed++;
        total++; if (r_ldata !== 32'h0) $display("FAIL lw_mis_data: got %h expected 0", r_ldata); else passed++;
        total++; if (r_stall_cyc != 1) $display("FAIL lw_mis_stall: got %0d expected 1", r_stall_cyc); else passed++;
        run_op(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
        total++; if (r_fault !== 1'b1 || r_req_cyc != 0) $display("FAIL st_illegal: got fault=%b req=%0d expected 1/0", r_fault, r_req_cyc); else passed++;
        run_op(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
        total++; if (r_fault !== 1'b1 || r_done_cyc != 1) $display("FAIL sh_mis: got fault=%b cyc=%0d expected 1/1", r_fault, r_done_cyc); else passed++;
        run_op(1'b1, 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
        total++; if (r_fault !== 1'b1) $display("FAIL ld_illegal: got %b expected 1", r_fault); else passed++;
    endtask

    task automatic test_delayed();
        run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 4, 2, 1'b1);
        total++; if (r_req_cyc != 5 || r_stable !== 1'b1) $display("FAIL dly_req: got cyc=%0d stable=%b expected 5/1", r_req_cyc, r_stable); else passed++;
        total++; if (r_stall_cyc != 9) $display("FAIL dly_stall: got %0d expected 9", r_stall_cyc); else passed++;
        total++; if (r_done_cyc != 9 || r_done_cnt != 1) $display("FAIL dly_done: got cyc=%0d cnt=%0d expected 9/1", r_done_cyc, r_done_cnt); else passed++;
        total++; if (r_ldata !== 32'h12345678) $display("FAIL dly_data: got %h expected 12345678", r_ldata); else passed++;
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        lsu_en = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h300;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; reset = 1'b1; lsu_en = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        total++; if ({mem_req, mem_we, mem_be, lsu_done, lsu_fault, stall} !== 9'd0) $display("FAIL rstmid_ctrl: got %b expected 0", {mem_req, mem_we, mem_be, lsu_done, lsu_fault, stall}); else passed++;
        total++; if ({mem_addr, mem_wdata, load_data} !== 96'd0) $display("FAIL rstmid_data: got %h expected 0", {mem_addr, mem_wdata, load_data}); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (lsu_done || mem_req) dones++;
        end
        total++; if (dones != 0) $display("FAIL rstmid_quiet: got %0d expected 0", dones); else passed++;
        run_op(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h0BADBEEF, 0, 0, 1'b0);
        total++; if (r_done_cyc != 3 || r_ldata !== 32'h0BADBEEF) $display("FAIL rstmid_recover: got cyc=%0d data=%h expected 3/0badbeef", r_done_cyc, r_ldata); else passed++;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_lb();
        test_lh();
        test_fault();
        test_delayed();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
